// File: rtl/dat_mem_arbiter.sv
// dat_mem_arbiter: shares one single-port DAT RAM between the CSR and CTL requesters.
// Rev 1.0 - fixed priority to CTL, CSR starvation guard, 1-cycle read response routing.
`default_nettype none

module dat_mem_arbiter #(
  parameter int DEPTH              = 128,
  parameter int WIDTH              = 64,
  parameter int DATA_BITS_PER_MASK = 32,
  parameter int ADDR_W             = $clog2(DEPTH),
  parameter int MAX_WAIT           = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              csr_req_i,
  input  logic              csr_write_i,
  input  logic [ADDR_W-1:0] csr_addr_i,
  input  logic [WIDTH-1:0]  csr_wdata_i,
  input  logic [WIDTH-1:0]  csr_wmask_i,
  output logic              csr_gnt_o,
  output logic              csr_rvalid_o,
  output logic [WIDTH-1:0]  csr_rdata_o,

  input  logic              ctl_req_i,
  input  logic              ctl_write_i,
  input  logic [ADDR_W-1:0] ctl_addr_i,
  input  logic [WIDTH-1:0]  ctl_wdata_i,
  input  logic [WIDTH-1:0]  ctl_wmask_i,
  output logic              ctl_gnt_o,
  output logic              ctl_rvalid_o,
  output logic [WIDTH-1:0]  ctl_rdata_o,

  output logic              mem_req_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WIDTH-1:0]  mem_wdata_o,
  output logic [WIDTH-1:0]  mem_wmask_o,
  input  logic [WIDTH-1:0]  mem_rdata_i,

  output logic [3:0]        starve_cnt_o
);

  localparam int         NUM_LANES  = WIDTH / DATA_BITS_PER_MASK;
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CSR  = 2'd1;
  localparam logic [1:0] OWN_CTL  = 2'd2;

  logic [3:0]       starve_cnt;
  logic [1:0]       owner;
  logic [1:0]       owner_next;
  logic             starved;
  logic             gnt_ctl;
  logic             gnt_csr;
  logic [WIDTH-1:0] mask_sel;

  // CSR only overtakes CTL once it has lost MAX_WAIT times in a row.
  always_comb begin
    starved = csr_req_i && (starve_cnt == MAX_WAIT_C);
    gnt_ctl = !rst_i && ctl_req_i && !starved;
    gnt_csr = !rst_i && csr_req_i && (!ctl_req_i || starved);
  end

  always_comb begin
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mask_sel    = '0;
    if (gnt_ctl) begin
      mem_write_o = ctl_write_i;
      mem_addr_o  = ctl_addr_i;
      mem_wdata_o = ctl_wdata_i;
      mask_sel    = ctl_wmask_i;
    end else if (gnt_csr) begin
      mem_write_o = csr_write_i;
      mem_addr_o  = csr_addr_i;
      mem_wdata_o = csr_wdata_i;
      mask_sel    = csr_wmask_i;
    end
  end

  // Mask is routed lane by lane, matching the RAM's per-word write enables.
  for (genvar lane = 0; lane < NUM_LANES; lane++) begin : g_mask_lane
    assign mem_wmask_o[lane*DATA_BITS_PER_MASK +: DATA_BITS_PER_MASK] =
      mask_sel[lane*DATA_BITS_PER_MASK +: DATA_BITS_PER_MASK];
  end

  assign mem_req_o = gnt_ctl | gnt_csr;
  assign ctl_gnt_o = gnt_ctl;
  assign csr_gnt_o = gnt_csr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (!csr_req_i || gnt_csr) begin
      starve_cnt <= '0;
    end else if (starve_cnt != MAX_WAIT_C) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign starve_cnt_o = starve_cnt;

  always_comb begin
    owner_next = OWN_NONE;
    if (gnt_ctl && !ctl_write_i) begin
      owner_next = OWN_CTL;
    end else if (gnt_csr && !csr_write_i) begin
      owner_next = OWN_CSR;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner <= OWN_NONE;
    end else begin
      owner <= owner_next;
    end
  end

  // A reset landing in the response cycle must still hide the pending read.
  assign ctl_rvalid_o = !rst_i && (owner == OWN_CTL);
  assign csr_rvalid_o = !rst_i && (owner == OWN_CSR);
  assign ctl_rdata_o  = ctl_rvalid_o ? mem_rdata_i : '0;
  assign csr_rdata_o  = csr_rvalid_o ? mem_rdata_i : '0;

endmodule

`default_nettype wire

// File: doc/dat_mem_arbiter.md
Name: dat_mem_arbiter

Overview:
- Shares one single-port DAT memory instance (1-cycle read latency, per-word masked writes) between two requesters.
- CSR requester: software DAT accesses from the register interface.
- CTL requester: the controller FSM's DAT lookups during bus transactions.
- Fixed priority to CTL, with a starvation guard for CSR. Sits between the I3C core and the DAT RAM in the top-level wrapper.

Parameters:
- Depth, 128: DAT entries. Must be a power of two.
- Width, 64: entry width in bits.
- DataBitsPerMask, 32: bits covered by each mask bit.
- AddrW, $clog2(Depth): address width.
- MaxWait, 4: consecutive CSR losses before CSR is force-granted. Range 1..15.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- csr_req_i  in  1  CSR access request; held until granted
- csr_write_i  in  1  1 = write, 0 = read
- csr_addr_i  in  AddrW  entry address
- csr_wdata_i  in  Width  write data
- csr_wmask_i  in  Width  bit write mask
- csr_gnt_o  out  1  CSR access accepted this cycle
- csr_rvalid_o  out  1  CSR read data valid
- csr_rdata_o  out  Width  CSR read data
- ctl_req_i, ctl_write_i, ctl_addr_i, ctl_wdata_i, ctl_wmask_i  in  1/1/AddrW/Width/Width  CTL request (same meaning as CSR)
- ctl_gnt_o, ctl_rvalid_o, ctl_rdata_o  out  1/1/Width  CTL grant and response
- mem_req_o  out  1  RAM request
- mem_write_o  out  1  RAM write enable
- mem_addr_o  out  AddrW  RAM address
- mem_wdata_o  out  Width  RAM write data
- mem_wmask_o  out  Width  RAM write mask
- mem_rdata_i  in  Width  RAM read data, valid the cycle after a read request
- starve_cnt_o  out  4  current CSR wait count (debug)

Behaviour:
- One clock (clk_i). Reset rst_i is synchronous, active-high; every flop is cleared on a clk_i edge while rst_i=1.
- Reset values:
  - All gnt_o, rvalid_o, mem_req_o = 0.
  - rdata_o, mem_addr_o, mem_wdata_o, mem_wmask_o, mem_write_o = 0.
  - starve_cnt_o = 0.
- While rst_i=1: no grants are issued and mem_req_o=0.
- Arbitration is combinational in the request cycle:
  - Only ctl_req_i: CTL granted.
  - Only csr_req_i: CSR granted.
  - Both requesting: CTL wins unless starve_cnt = MaxWait, in which case CSR wins.
  - At most one gnt_o high per cycle. A grant implies mem_req_o=1 in the same cycle.
- Mux: mem_write/addr/wdata/wmask carry the granted requester's fields. With no grant, mem_req_o=0 and the other mem outputs are 0.
- starve_cnt:
  - Increments (saturating at MaxWait) each cycle csr_req_i=1 and csr_gnt_o=0.
  - Resets to 0 on csr_gnt_o=1, or when csr_req_i=0.
- Requester rules: fields must stay stable while req is high and ungranted. Dropping req before grant is legal; the request is withdrawn and starve_cnt clears.
- Read response:
  - A registered owner tag (none/CSR/CTL) is captured on a granted read.
  - In the cycle after the grant, the owner's rvalid_o=1 for exactly one cycle, and its rdata_o = mem_rdata_i (combinational pass-through).
  - The non-owner's rdata_o = 0.
  - Writes produce no rvalid.
- Throughput: one access per cycle. Back-to-back reads to alternating owners yield consecutive rvalid pulses to the matching owner in grant order.
- Simultaneous new grant and previous read response are independent. The response targets the previous owner; the grant targets the new one.
- Reset asserted the cycle after a read grant: the rvalid is suppressed, since the tag is cleared and outputs are forced to 0.
- Write-then-read to the same address on consecutive cycles returns the new data; this ordering is guaranteed by the RAM.

Test Plan:
- CTL-only read of addr 0x05 after a write of 0xDEAD_BEEF_0000_1234 with all-ones mask -> ctl_gnt_o in the request cycle; ctl_rvalid_o one cycle later with rdata 0xDEAD_BEEF_0000_1234; csr_rvalid_o stays 0.
- Masked write: mask 0x0000_0000_FFFF_FFFF, data 0x1111_1111_2222_2222 over 0xAAAA_AAAA_BBBB_BBBB, then read -> 0xAAAA_AAAA_2222_2222.
- Both requesting continuously, MaxWait=4 -> CTL granted 4 cycles, CSR granted on the 5th; starve_cnt_o sequence 0,1,2,3,4,0; pattern repeats.
- Alternating grants: CTL read 0x01, then CSR read 0x02 -> ctl_rvalid_o at cycle+1 with entry 1, csr_rvalid_o at cycle+2 with entry 2; never both rvalids high together.
- CSR request withdrawn after 2 losses -> starve_cnt_o returns to 0; no csr_gnt_o issued.
- rst_i pulsed for 1 cycle immediately after a CTL read grant -> no ctl_rvalid_o; all outputs 0 the cycle after reset; a subsequent grant operates normally.
